// File: rtl/bcd_sum_display_if.sv
// ---------------------------------------------------------------------------
// bcd_sum_display_if
//
// Purpose: groups the load/digit inputs and the display outputs of the
// three-digit BCD seven-segment scanner into one bundle.
//
// Handshake: load is a plain capture strobe. There is no ready signal,
// because the scanner can always accept a new value. When load is high at
// a rising clk edge, Sum0/Sum1/Sum2 are captured at that edge.
//
// Signals:
//   load     master->slave  capture strobe
//   Sum0     master->slave  units BCD digit
//   Sum1     master->slave  tens BCD digit
//   Sum2     master->slave  hundreds/carry digit
//   seg      slave->master  active-low segments {g,f,e,d,c,b,a}
//   an       slave->master  active-low one-hot digit enable (an[0] = units)
//   frame    slave->master  one-cycle pulse in the last cycle of digit 2
//   err      slave->master  a latched digit is not a BCD code
//   dbg_ptr  slave->master  current scan state, for observation
// ---------------------------------------------------------------------------
interface bcd_sum_display_if;
    logic       load;
    logic [3:0] Sum0;
    logic [3:0] Sum1;
    logic [3:0] Sum2;
    logic [6:0] seg;
    logic [2:0] an;
    logic       frame;
    logic       err;
    logic [1:0] dbg_ptr;

    modport master (
        output load, Sum0, Sum1, Sum2,
        input  seg, an, frame, err, dbg_ptr
    );

    modport slave (
        input  load, Sum0, Sum1, Sum2,
        output seg, an, frame, err, dbg_ptr
    );
endinterface

// File: rtl/bcd_sum_display.sv
// ---------------------------------------------------------------------------
// bcd_sum_display
//
// Purpose: latches the three BCD result digits of the upstream adder and
// scans them onto a common-anode display, one digit at a time. Leading
// zeros on digits 2 and 1 can optionally be blanked. A non-BCD code is
// shown as a dash and raises err.
//
// Parameters:
//   SCAN_DIV  number of clock cycles each digit stays lit (2..65535)
//   BLANK_LZ  1 blanks leading zeros on digits 2 and 1
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    bcd_sum_display_if.slave. Carries load/Sum0..2 in, and
//          seg/an/frame/err/dbg_ptr out.
// ---------------------------------------------------------------------------
module bcd_sum_display #(
    parameter int SCAN_DIV = 4,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_sum_display_if.slave     bus
);

    localparam int              CW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } scan_state_t;

    logic [3:0]    r_d0;
    logic [3:0]    r_d1;
    logic [3:0]    r_d2;
    logic [CW-1:0] r_cnt;
    scan_state_t   r_ptr;

    logic          w_slot_end;
    logic [CW-1:0] w_cnt_nxt;
    scan_state_t   w_ptr_nxt;
    logic [3:0]    w_digit;
    logic          w_blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;   // non-BCD code: dash
        endcase
        return s;
    endfunction

    // State register, prescaler and holding registers.
    // A load never touches the scan, so a new value shows up in whichever
    // slot is active.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d0  <= 4'd0;
            r_d1  <= 4'd0;
            r_d2  <= 4'd0;
            r_cnt <= '0;
            r_ptr <= S0;
        end else begin
            if (bus.load) begin
                r_d0 <= bus.Sum0;
                r_d1 <= bus.Sum1;
                r_d2 <= bus.Sum2;
            end
            r_cnt <= w_cnt_nxt;
            r_ptr <= w_ptr_nxt;
        end
    end

    // Next-state logic. The counter wraps at SCAN_DIV-1 rather than at its
    // natural width, so that non-power-of-two dividers keep exact slots.
    always_comb begin
        w_slot_end = (r_cnt == CNT_MAX);
        w_cnt_nxt  = w_slot_end ? '0 : r_cnt + CW'(1);
        w_ptr_nxt  = r_ptr;
        case (r_ptr)
            S0:      if (w_slot_end) w_ptr_nxt = S1;
            S1:      if (w_slot_end) w_ptr_nxt = S2;
            S2:      if (w_slot_end) w_ptr_nxt = S0;
            default: w_ptr_nxt = S0;   // illegal code 3: recover immediately
        endcase
    end

    // Digit select and blanking. The blank tests compare against literal
    // zero, so an invalid code in D2/D1 is never blanked and shows a dash.
    always_comb begin
        w_digit = r_d0;
        w_blank = 1'b0;
        case (r_ptr)
            S1: begin
                w_digit = r_d1;
                w_blank = BLANK_LZ && (r_d2 == 4'd0) && (r_d1 == 4'd0);
            end
            S2: begin
                w_digit = r_d2;
                w_blank = BLANK_LZ && (r_d2 == 4'd0);
            end
            default: begin
                w_digit = r_d0;
                w_blank = 1'b0;
            end
        endcase
    end

    // Shifting by 3 pushes the one out of the 3-bit field, so an illegal
    // pointer turns every anode off.
    assign bus.an      = ~(3'b001 << r_ptr);
    assign bus.seg     = w_blank ? 7'h7F : seg7(w_digit);
    assign bus.frame   = (r_ptr == S2) && w_slot_end;
    assign bus.err     = (r_d0 > 4'd9) | (r_d1 > 4'd9) | (r_d2 > 4'd9);
    assign bus.dbg_ptr = r_ptr;

endmodule
